// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle RISC-V controller.
// Optional feature macro: MULTICYCLE_CONTROL_JAL_EN (adds the JAL state and decode).
package multicycle_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
`ifdef MULTICYCLE_CONTROL_JAL_EN
        StBeq      = 4'd9,
        StJal      = 4'd10
`else
        StBeq      = 4'd9
`endif
    } state_e;

    localparam logic [6:0] OpLw    = 7'b0000011;
    localparam logic [6:0] OpSw    = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        ResAluOut    = 2'b00,
        ResData      = 2'b01,
        ResAluResult = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        SrcAPc    = 2'b00,
        SrcAOldPc = 2'b01,
        SrcARd1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SrcBRd2  = 2'b00,
        SrcBImm  = 2'b01,
        SrcBFour = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ImmI = 2'b00,
        ImmS = 2'b01,
        ImmB = 2'b10,
        ImmJ = 2'b11
    } imm_src_e;

    // Opcodes the controller can sequence; anything else is flagged illegal in DECODE.
    function automatic logic is_supported_op(logic [6:0] op);
        case (op)
            OpLw, OpSw, OpRtype, OpItype, OpBeq: return 1'b1;
`ifdef MULTICYCLE_CONTROL_JAL_EN
            OpJal: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface multicycle_control_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal;
    logic       instr_done;

    modport master (
        input  op, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_op, imm_src, reg_write, illegal, instr_done
    );

    modport slave (
        output op, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_op, imm_src, reg_write, illegal, instr_done
    );
endinterface

// File: rtl/imm_src_decoder.sv
// Immediate format select from the opcode, independent of controller state.
// Honors MULTICYCLE_CONTROL_JAL_EN: without it, the JAL opcode falls back to I-format.
module imm_src_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] i_op,
    output logic [1:0] o_imm_src
);

    // Pure opcode decode; unknown opcodes default to I-format.
    always_comb begin
        o_imm_src = ImmI;
        case (i_op)
            OpSw:    o_imm_src = ImmS;
            OpBeq:   o_imm_src = ImmB;
`ifdef MULTICYCLE_CONTROL_JAL_EN
            OpJal:   o_imm_src = ImmJ;
`endif
            default: o_imm_src = ImmI;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: Moore FSM plus strobe gating on zero/mem_ready.
// Optional feature macro: MULTICYCLE_CONTROL_JAL_EN (JAL state and decode).
module multicycle_control
    import multicycle_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_control_if.master  mc_bus
);

    state_e     r_state;
    logic       w_pc_update;
    logic       w_branch;
    logic [1:0] w_imm_src;

    imm_src_decoder u_imm_src_decoder (
        .i_op      (mc_bus.op),
        .o_imm_src (w_imm_src)
    );

    assign mc_bus.imm_src  = w_imm_src;
    assign mc_bus.pc_write = w_pc_update | (w_branch & mc_bus.zero);

    // State register with next-state decode; reset and unused encodings return to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StFetch;
        end else begin
            case (r_state)
                StFetch:    if (mc_bus.mem_ready) r_state <= StDecode;
                StDecode: begin
                    case (mc_bus.op)
                        OpLw, OpSw: r_state <= StMemAdr;
                        OpRtype:    r_state <= StExecR;
                        OpItype:    r_state <= StExecI;
                        OpBeq:      r_state <= StBeq;
`ifdef MULTICYCLE_CONTROL_JAL_EN
                        OpJal:      r_state <= StJal;
`endif
                        default:    r_state <= StFetch;
                    endcase
                end
                StMemAdr:   r_state <= (mc_bus.op == OpLw) ? StMemRead : StMemWrite;
                StMemRead:  if (mc_bus.mem_ready) r_state <= StMemWb;
                StMemWb:    r_state <= StFetch;
                StMemWrite: if (mc_bus.mem_ready) r_state <= StFetch;
                StExecR:    r_state <= StAluWb;
                StExecI:    r_state <= StAluWb;
                StAluWb:    r_state <= StFetch;
                StBeq:      r_state <= StFetch;
`ifdef MULTICYCLE_CONTROL_JAL_EN
                StJal:      r_state <= StAluWb;
`endif
                default:    r_state <= StFetch;
            endcase
        end
    end

    // Per-state output decode; reset forces FETCH mux selects with every strobe low.
    always_comb begin
        w_pc_update        = 1'b0;
        w_branch           = 1'b0;
        mc_bus.adr_src     = 1'b0;
        mc_bus.mem_write   = 1'b0;
        mc_bus.ir_write    = 1'b0;
        mc_bus.result_src  = ResAluOut;
        mc_bus.alu_src_a   = SrcAPc;
        mc_bus.alu_src_b   = SrcBRd2;
        mc_bus.alu_op      = AluOpAdd;
        mc_bus.reg_write   = 1'b0;
        mc_bus.illegal     = 1'b0;
        mc_bus.instr_done  = 1'b0;
        if (reset) begin
            mc_bus.result_src = ResAluResult;
            mc_bus.alu_src_b  = SrcBFour;
        end else begin
            case (r_state)
                StFetch: begin
                    mc_bus.result_src = ResAluResult;
                    mc_bus.alu_src_b  = SrcBFour;
                    mc_bus.ir_write   = mc_bus.mem_ready;
                    w_pc_update       = mc_bus.mem_ready;
                end
                StDecode: begin
                    mc_bus.alu_src_a  = SrcAOldPc;
                    mc_bus.alu_src_b  = SrcBImm;
                    mc_bus.illegal    = !is_supported_op(mc_bus.op);
                    mc_bus.instr_done = !is_supported_op(mc_bus.op);
                end
                StMemAdr: begin
                    mc_bus.alu_src_a = SrcARd1;
                    mc_bus.alu_src_b = SrcBImm;
                end
                StMemRead: begin
                    mc_bus.adr_src = 1'b1;
                end
                StMemWb: begin
                    mc_bus.result_src = ResData;
                    mc_bus.reg_write  = 1'b1;
                    mc_bus.instr_done = 1'b1;
                end
                StMemWrite: begin
                    // Strobe held for the whole wait; completion marks the instruction done.
                    mc_bus.adr_src    = 1'b1;
                    mc_bus.mem_write  = 1'b1;
                    mc_bus.instr_done = mc_bus.mem_ready;
                end
                StExecR: begin
                    mc_bus.alu_src_a = SrcARd1;
                    mc_bus.alu_op    = AluOpFunct;
                end
                StExecI: begin
                    mc_bus.alu_src_a = SrcARd1;
                    mc_bus.alu_src_b = SrcBImm;
                    mc_bus.alu_op    = AluOpFunct;
                end
                StAluWb: begin
                    mc_bus.reg_write  = 1'b1;
                    mc_bus.instr_done = 1'b1;
                end
                StBeq: begin
                    mc_bus.alu_src_a  = SrcARd1;
                    mc_bus.alu_op     = AluOpSub;
                    w_branch          = 1'b1;
                    mc_bus.instr_done = 1'b1;
                end
`ifdef MULTICYCLE_CONTROL_JAL_EN
                StJal: begin
                    mc_bus.alu_src_a = SrcAOldPc;
                    mc_bus.alu_src_b = SrcBFour;
                    w_pc_update      = 1'b1;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle vector table plus
// hand-written reset-during-wait sequences, checked through a scoreboard queue.
module tb_multicycle_control;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    localparam logic [1:0] II = 2'b00;
    localparam logic [1:0] IS = 2'b01;
    localparam logic [1:0] IB = 2'b10;
`ifdef MULTICYCLE_CONTROL_JAL_EN
    localparam logic [1:0] IJ = 2'b11;
`else
    localparam logic [1:0] IJ = 2'b00;
`endif

    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic        zero;
        logic        mr;
        logic [16:0] exp;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    vec_t        vecs[$];
    logic [16:0] sb_exp[$];
    string       sb_name[$];
    int          checks = 0;
    int          errors = 0;

    multicycle_control_if mc_bus ();

    multicycle_control dut (
        .clk    (clk),
        .reset  (reset),
        .mc_bus (mc_bus)
    );

    always #5 clk = ~clk;

    // Packed order: pc_write adr_src mem_write ir_write result_src alu_src_a
    // alu_src_b alu_op imm_src reg_write illegal instr_done
    function automatic logic [16:0] ex(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sbs,
                                       input logic [1:0] ao, input logic [1:0] imm,
                                       input logic rw, input logic ill, input logic done);
        return {pcw, adr, mw, irw, rs, sa, sbs, ao, imm, rw, ill, done};
    endfunction

    function automatic logic [16:0] e_fetch(input logic mr, input logic [1:0] imm);
        return ex(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_decode(input logic ill, input logic [1:0] imm);
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0, ill, ill);
    endfunction
    function automatic logic [16:0] e_memadr(input logic [1:0] imm);
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_memread(input logic [1:0] imm);
        return ex(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_memwb(input logic [1:0] imm);
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, imm, 1'b1, 1'b0, 1'b1);
    endfunction
    function automatic logic [16:0] e_memwrite(input logic mr, input logic [1:0] imm);
        return ex(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0, mr);
    endfunction
    function automatic logic [16:0] e_execr(input logic [1:0] imm);
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, imm, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_execi(input logic [1:0] imm);
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, imm, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] e_aluwb(input logic [1:0] imm);
        return ex(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b1, 1'b0, 1'b1);
    endfunction
    function automatic logic [16:0] e_beq(input logic z, input logic [1:0] imm);
        return ex(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, imm, 1'b0, 1'b0, 1'b1);
    endfunction
    function automatic logic [16:0] e_jal(input logic [1:0] imm);
        return ex(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, imm, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic add(input logic rst, input logic [6:0] op, input logic z, input logic mr,
                       input logic [16:0] e, input string n);
        vec_t v;
        v.rst  = rst;
        v.op   = op;
        v.zero = z;
        v.mr   = mr;
        v.exp  = e;
        v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check_out();
        logic [16:0] got;
        logic [16:0] want;
        string       n;
        got = {mc_bus.pc_write, mc_bus.adr_src, mc_bus.mem_write, mc_bus.ir_write,
               mc_bus.result_src, mc_bus.alu_src_a, mc_bus.alu_src_b, mc_bus.alu_op,
               mc_bus.imm_src, mc_bus.reg_write, mc_bus.illegal, mc_bus.instr_done};
        want = sb_exp.pop_front();
        n    = sb_name.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, got, want);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, sample just before the rising edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        reset            = v.rst;
        mc_bus.op        = v.op;
        mc_bus.zero      = v.zero;
        mc_bus.mem_ready = v.mr;
        sb_exp.push_back(v.exp);
        sb_name.push_back(v.name);
        #4;
        check_out();
    endtask

    task automatic hs(input logic rst, input logic [6:0] op, input logic z, input logic mr,
                      input logic [16:0] e, input string n);
        vec_t v;
        v.rst  = rst;
        v.op   = op;
        v.zero = z;
        v.mr   = mr;
        v.exp  = e;
        v.name = n;
        step(v);
    endtask

    initial begin
        reset            = 1'b1;
        mc_bus.op        = RT;
        mc_bus.zero      = 1'b0;
        mc_bus.mem_ready = 1'b0;

        add(1'b1, RT, 1'b0, 1'b1, e_fetch(1'b0, II), "reset_prio_mr");
        add(1'b1, RT, 1'b1, 1'b0, e_fetch(1'b0, II), "reset_hold");
        add(1'b0, RT, 1'b0, 1'b0, e_fetch(1'b0, II), "fetch_wait");
        // R-type: 4 cycles
        add(1'b0, RT, 1'b0, 1'b1, e_fetch(1'b1, II), "r_fetch");
        add(1'b0, RT, 1'b0, 1'b1, e_decode(1'b0, II), "r_decode");
        add(1'b0, RT, 1'b0, 1'b1, e_execr(II), "r_execr");
        add(1'b0, RT, 1'b0, 1'b1, e_aluwb(II), "r_aluwb");
        // I-type ALU: 4 cycles
        add(1'b0, IT, 1'b0, 1'b1, e_fetch(1'b1, II), "i_fetch");
        add(1'b0, IT, 1'b0, 1'b1, e_decode(1'b0, II), "i_decode");
        add(1'b0, IT, 1'b0, 1'b1, e_execi(II), "i_execi");
        add(1'b0, IT, 1'b0, 1'b1, e_aluwb(II), "i_aluwb");
        // lw with three wait cycles: 8 cycles
        add(1'b0, LW, 1'b0, 1'b1, e_fetch(1'b1, II), "lw_fetch");
        add(1'b0, LW, 1'b0, 1'b1, e_decode(1'b0, II), "lw_decode");
        add(1'b0, LW, 1'b0, 1'b1, e_memadr(II), "lw_memadr");
        add(1'b0, LW, 1'b0, 1'b0, e_memread(II), "lw_wait1");
        add(1'b0, LW, 1'b0, 1'b0, e_memread(II), "lw_wait2");
        add(1'b0, LW, 1'b0, 1'b0, e_memread(II), "lw_wait3");
        add(1'b0, LW, 1'b0, 1'b1, e_memread(II), "lw_memread");
        add(1'b0, LW, 1'b0, 1'b1, e_memwb(II), "lw_memwb");
        // sw with one wait cycle
        add(1'b0, SW, 1'b0, 1'b1, e_fetch(1'b1, IS), "sw_fetch");
        add(1'b0, SW, 1'b0, 1'b1, e_decode(1'b0, IS), "sw_decode");
        add(1'b0, SW, 1'b0, 1'b1, e_memadr(IS), "sw_memadr");
        add(1'b0, SW, 1'b0, 1'b0, e_memwrite(1'b0, IS), "sw_wait");
        add(1'b0, SW, 1'b0, 1'b1, e_memwrite(1'b1, IS), "sw_done");
        // beq taken, with zero already high in DECODE
        add(1'b0, BQ, 1'b0, 1'b1, e_fetch(1'b1, IB), "beq1_fetch");
        add(1'b0, BQ, 1'b1, 1'b1, e_decode(1'b0, IB), "beq1_decode");
        add(1'b0, BQ, 1'b1, 1'b1, e_beq(1'b1, IB), "beq_taken");
        // beq not taken
        add(1'b0, BQ, 1'b0, 1'b1, e_fetch(1'b1, IB), "beq0_fetch");
        add(1'b0, BQ, 1'b0, 1'b1, e_decode(1'b0, IB), "beq0_decode");
        add(1'b0, BQ, 1'b0, 1'b1, e_beq(1'b0, IB), "beq_not_taken");
        // illegal opcode
        add(1'b0, BAD, 1'b0, 1'b1, e_fetch(1'b1, II), "ill_fetch");
        add(1'b0, BAD, 1'b0, 1'b1, e_decode(1'b1, II), "ill_decode");
        // jal
        add(1'b0, JL, 1'b0, 1'b1, e_fetch(1'b1, IJ), "jal_fetch");
`ifdef MULTICYCLE_CONTROL_JAL_EN
        add(1'b0, JL, 1'b0, 1'b1, e_decode(1'b0, IJ), "jal_decode");
        add(1'b0, JL, 1'b0, 1'b1, e_jal(IJ), "jal_jal");
        add(1'b0, JL, 1'b0, 1'b1, e_aluwb(IJ), "jal_aluwb");
`else
        add(1'b0, JL, 1'b0, 1'b1, e_decode(1'b1, IJ), "jal_illegal");
`endif
        add(1'b0, RT, 1'b0, 1'b0, e_fetch(1'b0, II), "back_in_fetch");

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Reset while waiting in MEMREAD, then release back into FETCH.
        hs(1'b0, LW, 1'b0, 1'b1, e_fetch(1'b1, II), "rlw_fetch");
        hs(1'b0, LW, 1'b0, 1'b1, e_decode(1'b0, II), "rlw_decode");
        hs(1'b0, LW, 1'b0, 1'b1, e_memadr(II), "rlw_memadr");
        hs(1'b0, LW, 1'b0, 1'b0, e_memread(II), "rlw_wait");
        hs(1'b1, LW, 1'b0, 1'b1, e_fetch(1'b0, II), "rlw_reset");
        hs(1'b0, LW, 1'b0, 1'b0, e_fetch(1'b0, II), "rlw_release");
        hs(1'b0, LW, 1'b0, 1'b1, e_fetch(1'b1, II), "rlw_refetch");
        hs(1'b0, LW, 1'b0, 1'b1, e_decode(1'b0, II), "rlw_redecode");
        hs(1'b0, LW, 1'b0, 1'b1, e_memadr(II), "rlw_rememadr");
        hs(1'b0, LW, 1'b0, 1'b1, e_memread(II), "rlw_rememread");
        hs(1'b0, LW, 1'b0, 1'b1, e_memwb(II), "rlw_rememwb");
        // Reset while waiting in MEMWRITE.
        hs(1'b0, SW, 1'b0, 1'b1, e_fetch(1'b1, IS), "rsw_fetch");
        hs(1'b0, SW, 1'b0, 1'b1, e_decode(1'b0, IS), "rsw_decode");
        hs(1'b0, SW, 1'b0, 1'b1, e_memadr(IS), "rsw_memadr");
        hs(1'b0, SW, 1'b0, 1'b0, e_memwrite(1'b0, IS), "rsw_wait");
        hs(1'b1, SW, 1'b0, 1'b1, e_fetch(1'b0, IS), "rsw_reset");
        hs(1'b0, SW, 1'b0, 1'b1, e_fetch(1'b1, IS), "rsw_release");
        hs(1'b0, SW, 1'b0, 1'b1, e_decode(1'b0, IS), "rsw_redecode");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
